// File: rtl/pipe_stage_reg.sv
// ============================================================================
// pipe_stage_reg : valid/ready pipeline stage register (pc, instr, payload)
//                  with stall, flush, bubble insertion, optional skid entry.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_stage_reg #(
    parameter int          PAYLOAD_W   = 64,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013,
    parameter bit          SKID_EN     = 1'b1,
    parameter int          STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_pc,
    input  logic [31:0]            in_instr,
    input  logic [PAYLOAD_W-1:0]   in_payload,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_pc,
    output logic [31:0]            out_instr,
    output logic [PAYLOAD_W-1:0]   out_payload,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic [31:0]          pc;
        logic [31:0]          instr;
        logic [PAYLOAD_W-1:0] payload;
    } entry_t;

    localparam entry_t C_BUBBLE = '{pc: 32'h0, instr: NOP_INSTR, payload: '0};

    logic   main_valid_q, main_valid_d;
    entry_t main_q, main_d;
    logic   skid_valid_q, skid_valid_d;
    entry_t skid_q, skid_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    logic   w_in_fire, w_out_fire, w_cnt_inc;
    entry_t w_in_entry;

    assign w_in_entry = '{pc: in_pc, instr: in_instr, payload: in_payload};
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = main_valid_q & out_ready & ~stall;
    assign w_cnt_inc  = (stall | (main_valid_q & ~out_ready)) & ~flush;

    generate
        if (SKID_EN) begin : g_skid_ready
            // Registered-only ready: the skid entry absorbs the one in-flight beat.
            assign in_ready = ~reset & ~stall & ~skid_valid_q;
        end else begin : g_comb_ready
            assign in_ready = ~reset & ~stall & (~main_valid_q | out_ready);
        end
    endgenerate

    always_comb begin
        main_valid_d = main_valid_q;
        main_d       = main_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            main_d       = C_BUBBLE;
            skid_valid_d = 1'b0;
            skid_d       = '0;
        end else if (w_out_fire) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_d       = skid_q;
                skid_valid_d = w_in_fire;
                skid_d       = w_in_fire ? w_in_entry : '0;
            end else begin
                main_valid_d = w_in_fire;
                main_d       = w_in_fire ? w_in_entry : C_BUBBLE;
            end
        end else if (!main_valid_q) begin
            if (w_in_fire) begin
                main_valid_d = 1'b1;
                main_d       = w_in_entry;
            end
        end else if (w_in_fire) begin
            skid_valid_d = 1'b1;
            skid_d       = w_in_entry;
        end
    end

    // Main entry is forced to the bubble pattern whenever it goes invalid,
    // so the outputs can be driven straight from the flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            main_q       <= C_BUBBLE;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
            stall_cnt_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_q       <= main_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
            if (w_cnt_inc && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign out_valid   = main_valid_q;
    assign out_pc      = main_q.pc;
    assign out_instr   = main_q.instr;
    assign out_payload = main_q.payload;
    assign stall_cnt   = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ============================================================================
// tb_pipe_stage_reg : directed + random stimulus against a queue-based model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg;

    localparam logic [31:0] C_NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, stall, flush, in_valid, out_ready;
    logic [31:0] in_pc, in_instr;
    logic [63:0] in_payload;

    logic        in_ready, out_valid;
    logic [31:0] out_pc, out_instr;
    logic [63:0] out_payload;
    logic [15:0] stall_cnt;

    logic        s_in_ready, s_out_valid;
    logic [31:0] s_out_pc, s_out_instr;
    logic [63:0] s_out_payload;
    logic [3:0]  s_stall_cnt;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_instr(in_instr), .in_payload(in_payload),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .out_payload(out_payload), .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.STALL_CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_pc(in_pc),
        .in_instr(in_instr), .in_payload(in_payload),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_pc(s_out_pc),
        .out_instr(s_out_instr), .out_payload(s_out_payload), .stall_cnt(s_stall_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Reference: FIFO of at most two held entries {pc, instr, payload}.
    logic [127:0] mq[$];
    int unsigned  mcnt = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cycle(output logic fired);
        logic [127:0] head, ent;
        logic         ev, eir, do_pop, do_push, inc;
        int unsigned  e16, e4;
        #1;
        if (reset) begin
            mq.delete();
            mcnt = 0;
        end
        ev   = (mq.size() > 0);
        head = ev ? mq[0] : {32'h0, C_NOP, 64'h0};
        eir  = !reset && !stall && (mq.size() < 2);
        e16  = (mcnt > 65535) ? 65535 : mcnt;
        e4   = (mcnt > 15) ? 15 : mcnt;
        check_eq("out_valid",   {63'h0, out_valid},   {63'h0, ev});
        check_eq("out_pc",      {32'h0, out_pc},      {32'h0, head[127:96]});
        check_eq("out_instr",   {32'h0, out_instr},   {32'h0, head[95:64]});
        check_eq("out_payload", out_payload,          head[63:0]);
        check_eq("in_ready",    {63'h0, in_ready},    {63'h0, eir});
        check_eq("stall_cnt",   {48'h0, stall_cnt},   64'(e16));
        check_eq("sat_cnt",     {60'h0, s_stall_cnt}, 64'(e4));
        check_eq("sat_pc",      {32'h0, s_out_pc},    {32'h0, head[127:96]});
        check_eq("sat_ready",   {63'h0, s_in_ready},  {63'h0, eir});
        do_pop  = ev && out_ready && !stall;
        do_push = in_valid && eir;
        inc     = (stall || (ev && !out_ready)) && !flush;
        ent     = {in_pc, in_instr, in_payload};
        fired   = do_push;
        @(posedge clk);
        if (reset) begin
            mq.delete();
            mcnt = 0;
        end else if (flush) begin
            mq.delete();
        end else begin
            if (inc) mcnt++;
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(ent);
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic ordy,
                         input logic stl, input logic fl);
        logic f;
        in_valid   = v;
        in_pc      = pc;
        in_instr   = $urandom;
        in_payload = {$urandom, $urandom};
        out_ready  = ordy;
        stall      = stl;
        flush      = fl;
        cycle(f);
    endtask

    logic        pend_v, f;
    logic [31:0] pend_pc;

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0; in_payload = '0;
        @(negedge clk);
        cycle(f);
        cycle(f);
        reset = 1'b0;

        // Streaming pc 0,4,8,...
        for (int i = 0; i < 8; i++) drive(1'b1, 32'(i * 4), 1'b1, 1'b0, 1'b0);
        check_eq("stream_pc", {32'h0, out_pc}, 64'h1C);

        // Asynchronous reset mid-stream, seen before the next clock edge.
        reset = 1'b1;
        #2;
        check_eq("rst_valid", {63'h0, out_valid}, 64'h0);
        check_eq("rst_instr", {32'h0, out_instr}, {32'h0, C_NOP});
        check_eq("rst_cnt",   {48'h0, stall_cnt}, 64'h0);
        cycle(f);
        reset = 1'b0;

        // Backpressure into the skid entry, then drain in order.
        drive(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h14, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h18, 1'b0, 1'b0, 1'b0);
        check_eq("bp_hold", {32'h0, out_pc}, 64'h10);
        check_eq("bp_rdy",  {63'h0, in_ready}, 64'h0);
        drive(1'b1, 32'h18, 1'b1, 1'b0, 1'b0);
        check_eq("bp_out1", {32'h0, out_pc}, 64'h14);
        drive(1'b1, 32'h18, 1'b1, 1'b0, 1'b0);
        check_eq("bp_out2", {32'h0, out_pc}, 64'h18);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Stall with a valid entry held.
        drive(1'b1, 32'h40, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h44, 1'b1, 1'b1, 1'b0);
        check_eq("stall_pc", {32'h0, out_pc}, 64'h40);

        // Flush with stall, full skid and an offered entry.
        drive(1'b1, 32'h50, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h54, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hDEAD, 1'b0, 1'b1, 1'b1);
        check_eq("flush_valid", {63'h0, out_valid}, 64'h0);
        check_eq("flush_instr", {32'h0, out_instr}, {32'h0, C_NOP});
        for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Long stall: 4-bit counter must saturate.
        for (int i = 0; i < 20; i++) drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        check_eq("sat_F", {60'h0, s_stall_cnt}, 64'hF);

        // Random traffic; the source holds an offered entry until it is taken.
        pend_v = 1'b0; pend_pc = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pend_v && ($urandom_range(0, 3) != 0)) begin
                pend_v  = 1'b1;
                pend_pc = $urandom;
            end
            in_valid   = pend_v;
            in_pc      = pend_pc;
            in_instr   = $urandom;
            in_payload = {$urandom, $urandom};
            out_ready  = ($urandom_range(0, 2) != 0);
            stall      = ($urandom_range(0, 7) == 0);
            flush      = ($urandom_range(0, 31) == 0);
            cycle(f);
            if (f) pend_v = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
